// File: rtl/serial_tx_param.sv
// serial_tx_param: parametrised single-wire serial transmitter.
// Accepts a word on a valid/ready handshake and shifts it out as
// start bit, DATA_W data bits, optional parity bit and STOP_BITS stop bits.
// Each bit lasts CLKS_PER_BIT clocks.
// The word being sent is mirrored on led.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// after the data bits.

module serial_tx_param #(
  parameter int   DATA_W       = 8,
  parameter int   CLKS_PER_BIT = 10_000_000,
  parameter int   STOP_BITS    = 1,
  parameter logic IDLE_LEVEL   = 1'b0,
  parameter logic LSB_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] led
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Wide enough for both the data-bit index and the stop-bit index.
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cycle_cnt, cycle_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [DATA_W-1:0] shift_q, shift_next;
  logic [DATA_W-1:0] led_next;
  logic              line_next, busy_next, ready_next, done_next;

  logic              accept;
  logic              bit_end;
  logic              last_data;
  logic              last_stop;
  logic              out_bit;
  logic [DATA_W-1:0] shifted;

  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (cycle_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt == BIT_W'(DATA_W - 1));
  assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign out_bit   = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
  assign shifted   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each bit period ends when the cycle counter wraps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end && last_data) begin
`ifdef SERIAL_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP:  if (bit_end && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values: the line level for the coming bit is
  // computed here so tx_line changes on the same edge as the state.
  always_comb begin
    line_next  = tx_line;
    busy_next  = busy;
    ready_next = tx_ready;
    done_next  = 1'b0;
    led_next   = led;
    shift_next = shift_q;
    bit_next   = bit_cnt;
    cycle_next = bit_end ? '0 : cycle_cnt + 1'b1;
    case (state)
      IDLE: begin
        cycle_next = '0;
        bit_next   = '0;
        line_next  = IDLE_LEVEL;
        if (accept) begin
          shift_next = tx_data;
          led_next   = tx_data;
          line_next  = ~IDLE_LEVEL;
          busy_next  = 1'b1;
          ready_next = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          line_next  = out_bit;
          shift_next = shifted;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bit_next = '0;
`ifdef SERIAL_TX_PARITY_EN
            // led still holds the accepted word, so it doubles as the
            // source for the parity reduction.
            line_next = ^led;
`else
            line_next = IDLE_LEVEL;
`endif
          end else begin
            line_next  = out_bit;
            shift_next = shifted;
            bit_next   = bit_cnt + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          line_next = IDLE_LEVEL;
          bit_next  = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            line_next  = IDLE_LEVEL;
            busy_next  = 1'b0;
            ready_next = 1'b1;
            done_next  = 1'b1;
            bit_next   = '0;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        line_next = IDLE_LEVEL;
      end
    endcase
  end

  // Registered outputs and counters; reset forces the idle line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_line   <= IDLE_LEVEL;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      led       <= '0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      cycle_cnt <= '0;
    end else begin
      tx_line   <= line_next;
      tx_ready  <= ready_next;
      busy      <= busy_next;
      done      <= done_next;
      led       <= led_next;
      shift_q   <= shift_next;
      bit_cnt   <= bit_next;
      cycle_cnt <= cycle_next;
    end
  end

endmodule

// File: tb/tb_serial_tx_param.sv
// tb_serial_tx_param: directed bench for serial_tx_param.
// Two instances: "a" is 8 bits, 4 clocks/bit, idle low, LSB first, 1 stop bit;
// "b" is the same but idle high, MSB first, 2 stop bits.
// Expected line patterns are written out per bit period, first period leftmost.
// Build with SERIAL_TX_PARITY_EN to select the parity frame patterns.

module tb_serial_tx_param;

  localparam int CPB = 4;

`ifdef SERIAL_TX_PARITY_EN
  localparam logic [0:15] LV_B3 = 16'b1110_0110_1100_0000;
  localparam int          PR_B3 = 11;
  localparam logic [0:15] LV_01 = 16'b0000_0000_1111_0000;
  localparam int          PR_01 = 12;
  localparam logic [0:15] LV_A5 = 16'b1101_0010_1000_0000;
  localparam int          PR_A5 = 11;
  localparam logic [0:15] LV_5A = 16'b1010_1101_0000_0000;
  localparam int          PR_5A = 11;
`else
  localparam logic [0:15] LV_B3 = 16'b1110_0110_1000_0000;
  localparam int          PR_B3 = 10;
  localparam logic [0:15] LV_01 = 16'b0000_0000_1110_0000;
  localparam int          PR_01 = 11;
  localparam logic [0:15] LV_A5 = 16'b1101_0010_1000_0000;
  localparam int          PR_A5 = 10;
  localparam logic [0:15] LV_5A = 16'b1010_1101_0000_0000;
  localparam int          PR_5A = 10;
`endif

  logic       clk;
  logic       rst;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, ready_b;
  logic       line_a, line_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic [7:0] led_a, led_b;

  int total;
  int bad;

  serial_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
    .IDLE_LEVEL(1'b0), .LSB_FIRST(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .tx_line(line_a), .busy(busy_a),
    .done(done_a), .led(led_a)
  );

  serial_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
    .IDLE_LEVEL(1'b1), .LSB_FIRST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .tx_line(line_b), .busy(busy_b),
    .done(done_b), .led(led_b)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_line(input int which);
    return (which == 0) ? line_a : line_b;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 0) ? done_a : done_b;
  endfunction

  function automatic logic get_ready(input int which);
    return (which == 0) ? ready_a : ready_b;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one word and returns at the negedge
  // right after the accepting posedge (cycle 0 of the frame).
  task automatic apply_stimulus(input int which, input logic [7:0] word);
    if (which == 0) begin
      valid_a = 1'b1;
      data_a  = word;
    end else begin
      valid_b = 1'b1;
      data_b  = word;
    end
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Walks a whole frame from cycle 0 and ends at the negedge where done is up.
  task automatic check_frame(input int which, input string tag,
                             input logic [0:15] lv, input int periods,
                             input logic idle);
    int len;
    len = periods * CPB;
    for (int k = 0; k < len; k++) begin
      check_output($sformatf("%s line k=%0d", tag, k),
                   32'(get_line(which)), 32'(lv[k / CPB]));
      check_output($sformatf("%s busy k=%0d", tag, k),
                   32'(get_busy(which)), 32'd1);
      check_output($sformatf("%s done k=%0d", tag, k),
                   32'(get_done(which)), 32'd0);
      @(negedge clk);
    end
    check_output({tag, " done_end"},  32'(get_done(which)),  32'd1);
    check_output({tag, " busy_end"},  32'(get_busy(which)),  32'd0);
    check_output({tag, " ready_end"}, 32'(get_ready(which)), 32'd1);
    check_output({tag, " line_end"},  32'(get_line(which)),  32'(idle));
  endtask

  // Directed sequence covering reset, both configurations, back-to-back
  // words and a reset in the middle of a frame.
  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = 8'h00;
    data_b  = 8'h00;

    repeat (2) @(negedge clk);
    check_output("rst line_a",  32'(line_a),  32'd0);
    check_output("rst ready_a", 32'(ready_a), 32'd1);
    check_output("rst busy_a",  32'(busy_a),  32'd0);
    check_output("rst done_a",  32'(done_a),  32'd0);
    check_output("rst led_a",   32'(led_a),   32'h00);
    check_output("rst line_b",  32'(line_b),  32'd1);
    check_output("rst ready_b", 32'(ready_b), 32'd1);
    check_output("rst busy_b",  32'(busy_b),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("idle line_a", 32'(line_a), 32'd0);

    $display("[TB] frame 0xB3 on a");
    apply_stimulus(0, 8'hB3);
    check_output("b3 led", 32'(led_a), 32'hB3);
    check_frame(0, "b3", LV_B3, PR_B3, 1'b0);
    @(negedge clk);
    check_output("b3 done_pulse", 32'(done_a), 32'd0);
    check_output("b3 led_hold",   32'(led_a),  32'hB3);

    $display("[TB] frame 0x01 on b");
    apply_stimulus(1, 8'h01);
    check_output("01 led", 32'(led_b), 32'h01);
    check_frame(1, "01", LV_01, PR_01, 1'b1);
    @(negedge clk);
    check_output("01 done_pulse", 32'(done_b), 32'd0);
    check_output("01 line_idle",  32'(line_b), 32'd1);

    $display("[TB] back-to-back 0xA5 then 0x5A on a");
    valid_a = 1'b1;
    data_a  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    data_a  = 8'h5A;
    check_frame(0, "a5", LV_A5, PR_A5, 1'b0);
    check_output("a5 led_kept", 32'(led_a), 32'hA5);
    @(negedge clk);
    valid_a = 1'b0;
    check_output("5a accept_ready", 32'(ready_a), 32'd0);
    check_output("5a accept_led",   32'(led_a),   32'h5A);
    check_output("5a done_low",     32'(done_a),  32'd0);
    check_frame(0, "5a", LV_5A, PR_5A, 1'b0);
    @(negedge clk);

    $display("[TB] reset during data bit 3 on a");
    apply_stimulus(0, 8'h5A);
    repeat (17) @(negedge clk);
    check_output("mid line_bit3", 32'(line_a), 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid line",  32'(line_a),  32'd0);
    check_output("mid ready", 32'(ready_a), 32'd1);
    check_output("mid busy",  32'(busy_a),  32'd0);
    check_output("mid led",   32'(led_a),   32'h00);
    check_output("mid done",  32'(done_a),  32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("mid done_hold", 32'(done_a), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check_output($sformatf("mid no_done k=%0d", k), 32'(done_a), 32'd0);
    end
    apply_stimulus(0, 8'hB3);
    check_frame(0, "post", LV_B3, PR_B3, 1'b0);
    check_output("post led", 32'(led_a), 32'hB3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
